// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
//   Instruction handshake bundle between an instruction source and
//   alu_issue_stage. A transfer happens on a rising clock edge where
//   in_valid and in_ready are both high.
// Signals:
//   in_valid   source -> stage   instruction present
//   in_ready   stage  -> source  stage can accept
//   in_opcode  source -> stage   4-bit operation code
//   in_rd      source -> stage   destination register
//   in_rs      source -> stage   source register feeding ALU a
//   in_rt      source -> stage   source register feeding ALU b
interface alu_issue_stage_if #(
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs;
  logic [AW-1:0] in_rt;

  // Instruction source side
  modport master (
    output in_valid, in_opcode, in_rd, in_rs, in_rt,
    input  in_ready
  );

  // Issue stage side
  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs, in_rt,
    output in_ready
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Operand/issue stage in front of the combinational alu_16bit. Accepts
//   3-operand register instructions, reads rs/rt from an internal 8x16
//   register file (r0 reads as zero), decodes the opcode into ALU controls,
//   holds them for one cycle, then writes the ALU result back to rd and
//   updates the Z/C/V flags. Sequence is IDLE -> ISSUE -> WB -> IDLE, so
//   wb_valid appears two cycles after acceptance and at most one
//   instruction is taken every three cycles.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_if               instruction handshake (slave side)
//   ld_en/addr/data     host register load, honoured in every state
//   dbg_addr/dbg_data   combinational register file read
//   alu_a/alu_b         registered operands to the ALU
//   alu_op/ainvert/
//   bnegate/cin         registered ALU controls
//   alu_result/cout/
//   zero/overflow       ALU response, sampled at the end of ISSUE
//   wb_valid/rd/data    one-cycle writeback report
//   flag_z/c/v          flags of the last completed instruction
//   err                 one-cycle pulse after an illegal opcode is accepted
module alu_issue_stage #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_stage_if.slave  in_if,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_ainvert,
  output logic              alu_bnegate,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WB    = 2'd2;

  localparam logic [3:0] OPC_MOV = 4'd7;

  logic [1:0]        state;
  logic [DATA_W-1:0] regs [NREG];
  logic [AW-1:0]     rd_q;

  logic              accept;
  logic              illegal;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [2:0]        dec_op;
  logic              dec_ainv;
  logic              dec_bneg;
  logic              dec_cin;

  assign in_if.in_ready = (state == S_IDLE);
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign illegal        = in_if.in_opcode[3];
  assign wb_valid       = (state == S_WB);

  // r0 is hard-wired to zero on every read port
  assign rs_val   = (in_if.in_rs == '0) ? '0 : regs[in_if.in_rs];
  assign rt_val   = (in_if.in_rt == '0) ? '0 : regs[in_if.in_rt];
  assign dbg_data = (dbg_addr == '0)    ? '0 : regs[dbg_addr];

  // Opcode to ALU control decode. SUB and SLT invert b and inject a
  // carry to form a - b; NOR and NAND use De Morgan on the AND/OR paths.
  // MOV is an ADD with b forced to zero at operand latch time.
  always_comb begin
    dec_op   = 3'b000;
    dec_ainv = 1'b0;
    dec_bneg = 1'b0;
    dec_cin  = 1'b0;
    case (in_if.in_opcode)
      4'd0: dec_op = 3'b000;
      4'd1: dec_op = 3'b001;
      4'd2: dec_op = 3'b010;
      4'd3: begin dec_op = 3'b010; dec_bneg = 1'b1; dec_cin = 1'b1; end
      4'd4: begin dec_op = 3'b011; dec_bneg = 1'b1; dec_cin = 1'b1; end
      4'd5: begin dec_op = 3'b000; dec_ainv = 1'b1; dec_bneg = 1'b1; end
      4'd6: begin dec_op = 3'b001; dec_ainv = 1'b1; dec_bneg = 1'b1; end
      4'd7: dec_op = 3'b010;
      default: dec_op = 3'b000;
    endcase
  end

  // Sequencer and datapath registers. Operands are captured from the
  // pre-edge register file, so a load on the accept edge never reaches
  // the latched operands. Illegal opcodes are consumed in IDLE and only
  // produce the err pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rd_q        <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_ainvert <= 1'b0;
      alu_bnegate <= 1'b0;
      alu_cin     <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      flag_v      <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= accept && illegal;
      case (state)
        S_IDLE: begin
          if (accept && !illegal) begin
            rd_q        <= in_if.in_rd;
            alu_a       <= rs_val;
            alu_b       <= (in_if.in_opcode == OPC_MOV) ? '0 : rt_val;
            alu_op      <= dec_op;
            alu_ainvert <= dec_ainv;
            alu_bnegate <= dec_bneg;
            alu_cin     <= dec_cin;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          flag_z  <= alu_zero;
          flag_c  <= alu_cout;
          flag_v  <= alu_overflow;
          wb_rd   <= rd_q;
          wb_data <= alu_result;
          state   <= S_WB;
        end
        S_WB: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Register file. The writeback assignment comes after the host load so
  // that it takes precedence when both target the same register on one
  // edge. Writes to r0 are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (ld_en && (ld_addr != '0)) begin
        regs[ld_addr] <= ld_data;
      end
      if ((state == S_ISSUE) && (rd_q != '0)) begin
        regs[rd_q] <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
//   Bench for alu_issue_stage. A behavioural stand-in for alu_16bit answers
//   the stage's ALU controls. Expected results come from a table of
//   hand-derived vectors and from a reference model that computes each
//   opcode's meaning with plain arithmetic on a shadow register array.
module tb_alu_issue_stage;

  typedef struct {
    bit         isLoad;
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [15:0] data;
    logic [2:0] zcv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_ainvert, alu_bnegate, alu_cin;
  logic [15:0] alu_result;
  logic        alu_cout, alu_zero, alu_overflow;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        flag_z, flag_c, flag_v, err;

  logic [15:0] model [8];
  logic [2:0]  modelZcv;
  logic [5:0]  decTab [8];
  int          nCompared;
  int          nMismatched;

  alu_issue_stage_if #(.AW(3)) bus ();

  alu_issue_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_if        (bus),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_ainvert  (alu_ainvert),
    .alu_bnegate  (alu_bnegate),
    .alu_cin      (alu_cin),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .flag_v       (flag_v),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Stand-in for alu_16bit: invert stages, ripple adder, SLT from the
  // sign of a - b corrected by overflow
  logic [15:0] stA, stB;
  logic [16:0] stSum;
  always_comb begin
    stA          = alu_ainvert ? ~alu_a : alu_a;
    stB          = alu_bnegate ? ~alu_b : alu_b;
    stSum        = {1'b0, stA} + {1'b0, stB} + {16'b0, alu_cin};
    alu_cout     = stSum[16];
    alu_overflow = (stA[15] == stB[15]) && (stSum[15] != stA[15]);
    case (alu_op)
      3'd0:    alu_result = stA & stB;
      3'd1:    alu_result = stA | stB;
      3'd2:    alu_result = stSum[15:0];
      3'd3:    alu_result = {15'b0, stSum[15] ^ alu_overflow};
      default: alu_result = 16'h0000;
    endcase
    alu_zero = (alu_result == 16'h0000);
  end

  // Reference semantics of each opcode. Carry and overflow describe the
  // addition the ALU performs for that opcode, computed with integers.
  function automatic void refExec(input logic [3:0] op, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] res,
                                  output logic [2:0] zcv);
    logic [15:0] xb, yb;
    int ci, us, ss;
    xb = a; yb = b; ci = 0;
    case (op)
      4'd0: res = a & b;
      4'd1: res = a | b;
      4'd2: res = a + b;
      4'd3: begin res = a - b; yb = ~b; ci = 1; end
      4'd4: begin res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0; yb = ~b; ci = 1; end
      4'd5: begin res = ~(a | b); xb = ~a; yb = ~b; end
      4'd6: begin res = ~(a & b); xb = ~a; yb = ~b; end
      default: begin res = a; yb = 16'h0000; end
    endcase
    us = int'(xb) + int'(yb) + ci;
    ss = int'($signed(xb)) + int'($signed(yb)) + ci;
    zcv = {res == 16'h0000, us > 65535, (ss > 32767) || (ss < -32768)};
  endfunction

  function automatic vec_t mkVec(input bit l, input logic [3:0] op, input logic [2:0] rd,
                                 input logic [2:0] rs, input logic [2:0] rt,
                                 input logic [15:0] d, input logic [2:0] f);
    vec_t v;
    v.isLoad = l; v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.data = d; v.zcv = f;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic modelLoad(input logic [2:0] a, input logic [15:0] d);
    if (a != 3'd0) model[a] = d;
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      checkOutput($sformatf("%s_r%0d", tag, i), dbg_data, model[i]);
    end
    @(negedge clk);
  endtask

  task automatic loadReg(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    modelLoad(a, d);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // One instruction, starting and ending on a falling edge with the stage
  // idle. ldMode 1 loads on the accept edge, 2 on the writeback edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [2:0] rd,
                               input logic [2:0] rs, input logic [2:0] rt,
                               input int ldMode, input logic [2:0] ldA,
                               input logic [15:0] ldD, output logic [15:0] gotData,
                               output logic [2:0] gotZcv);
    logic [15:0] expA, expB, expRes;
    logic [2:0]  expZcv;
    gotData = 16'h0; gotZcv = 3'b0;
    checkOutput("ready_idle", {15'b0, bus.in_ready}, 16'd1);
    expA = model[rs];
    expB = (op == 4'd7) ? 16'h0000 : model[rt];
    bus.in_valid = 1'b1; bus.in_opcode = op;
    bus.in_rd = rd; bus.in_rs = rs; bus.in_rt = rt;
    if (ldMode == 1) begin ld_en = 1'b1; ld_addr = ldA; ld_data = ldD; end
    @(posedge clk);
    if (ldMode == 1) modelLoad(ldA, ldD);
    @(negedge clk);
    bus.in_valid = 1'b0; ld_en = 1'b0;
    if (op[3]) begin
      checkOutput("err_pulse", {15'b0, err}, 16'd1);
      checkOutput("illegal_no_wb", {15'b0, wb_valid}, 16'd0);
      checkOutput("illegal_ready", {15'b0, bus.in_ready}, 16'd1);
      checkOutput("illegal_flags", {13'b0, flag_z, flag_c, flag_v}, {13'b0, modelZcv});
      @(negedge clk);
      checkOutput("err_clear", {15'b0, err}, 16'd0);
      checkOutput("illegal_no_wb2", {15'b0, wb_valid}, 16'd0);
    end else begin
      checkOutput("ready_issue", {15'b0, bus.in_ready}, 16'd0);
      checkOutput("alu_a", alu_a, expA);
      checkOutput("alu_b", alu_b, expB);
      checkOutput("alu_ctl", {10'b0, alu_op, alu_ainvert, alu_bnegate, alu_cin},
                  {10'b0, decTab[op[2:0]]});
      checkOutput("wb_early", {15'b0, wb_valid}, 16'd0);
      if (ldMode == 2) begin ld_en = 1'b1; ld_addr = ldA; ld_data = ldD; end
      @(posedge clk);
      refExec(op, expA, expB, expRes, expZcv);
      if (ldMode == 2) modelLoad(ldA, ldD);
      modelLoad(rd, expRes);
      modelZcv = expZcv;
      @(negedge clk);
      ld_en = 1'b0;
      checkOutput("wb_valid", {15'b0, wb_valid}, 16'd1);
      checkOutput("wb_rd", {13'b0, wb_rd}, {13'b0, rd});
      checkOutput("wb_data", wb_data, expRes);
      checkOutput("flags", {13'b0, flag_z, flag_c, flag_v}, {13'b0, expZcv});
      checkOutput("ready_wb", {15'b0, bus.in_ready}, 16'd0);
      gotData = wb_data;
      gotZcv  = {flag_z, flag_c, flag_v};
      @(negedge clk);
      checkOutput("wb_drop", {15'b0, wb_valid}, 16'd0);
      checkOutput("ready_back", {15'b0, bus.in_ready}, 16'd1);
      checkOutput("flags_hold", {13'b0, flag_z, flag_c, flag_v}, {13'b0, modelZcv});
    end
  endtask

  initial begin
    vec_t        vecs [$];
    logic [15:0] gD, resA, resB, opA, opB;
    logic [2:0]  gF, zA, zB;
    logic [15:0] pool [4];
    int          acceptEdge;

    decTab[0] = 6'b000_000; decTab[1] = 6'b001_000;
    decTab[2] = 6'b010_000; decTab[3] = 6'b010_011;
    decTab[4] = 6'b011_011; decTab[5] = 6'b000_110;
    decTab[6] = 6'b001_110; decTab[7] = 6'b010_000;
    pool[0] = 16'h7FFF; pool[1] = 16'h8000; pool[2] = 16'hFFFF; pool[3] = 16'h0000;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    modelZcv = 3'b000;
    nCompared = 0; nMismatched = 0;

    // {isLoad, opcode, rd, rs, rt, load data / expected wb_data, expected ZCV}
    vecs.push_back(mkVec(1, 4'd0, 3'd1, 3'd0, 3'd0, 16'h0005, 3'b000));
    vecs.push_back(mkVec(1, 4'd0, 3'd2, 3'd0, 3'd0, 16'h0003, 3'b000));
    vecs.push_back(mkVec(0, 4'd2, 3'd3, 3'd1, 3'd2, 16'h0008, 3'b000));
    vecs.push_back(mkVec(0, 4'd3, 3'd4, 3'd2, 3'd1, 16'hFFFE, 3'b000));
    vecs.push_back(mkVec(0, 4'd3, 3'd5, 3'd1, 3'd1, 16'h0000, 3'b110));
    vecs.push_back(mkVec(0, 4'd0, 3'd6, 3'd1, 3'd2, 16'h0001, 3'b000));
    vecs.push_back(mkVec(0, 4'd1, 3'd7, 3'd1, 3'd2, 16'h0007, 3'b000));
    vecs.push_back(mkVec(0, 4'd5, 3'd6, 3'd1, 3'd2, 16'hFFF8, 3'b010));
    vecs.push_back(mkVec(0, 4'd6, 3'd7, 3'd1, 3'd2, 16'hFFFE, 3'b010));
    vecs.push_back(mkVec(0, 4'd7, 3'd3, 3'd4, 3'd1, 16'hFFFE, 3'b000));
    vecs.push_back(mkVec(1, 4'd0, 3'd1, 3'd0, 3'd0, 16'h7FFF, 3'b000));
    vecs.push_back(mkVec(1, 4'd0, 3'd2, 3'd0, 3'd0, 16'h0001, 3'b000));
    vecs.push_back(mkVec(0, 4'd2, 3'd3, 3'd1, 3'd2, 16'h8000, 3'b001));
    vecs.push_back(mkVec(0, 4'd4, 3'd6, 3'd2, 3'd1, 16'h0001, 3'b000));
    vecs.push_back(mkVec(0, 4'd4, 3'd6, 3'd1, 3'd2, 16'h0000, 3'b110));
    vecs.push_back(mkVec(0, 4'd2, 3'd0, 3'd1, 3'd2, 16'h8000, 3'b001));

    rst_n = 1'b0; ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'h0; dbg_addr = 3'd0;
    bus.in_valid = 1'b0; bus.in_opcode = 4'd0;
    bus.in_rd = 3'd0; bus.in_rs = 3'd0; bus.in_rt = 3'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_wb_valid", {15'b0, wb_valid}, 16'd0);
    checkOutput("rst_err", {15'b0, err}, 16'd0);
    checkOutput("rst_flags", {13'b0, flag_z, flag_c, flag_v}, 16'd0);
    checkOutput("rst_alu_a", alu_a, 16'd0);
    checkOutput("rst_alu_b", alu_b, 16'd0);
    checkOutput("rst_alu_ctl", {10'b0, alu_op, alu_ainvert, alu_bnegate, alu_cin}, 16'd0);
    checkOutput("rst_wb", {wb_rd, wb_data[12:0]} | {13'b0, wb_data[15:13]}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", {15'b0, bus.in_ready}, 16'd1);
    checkRegs("rst");

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      if (vecs[i].isLoad) begin
        loadReg(vecs[i].rd, vecs[i].data);
      end else begin
        applyStimulus(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, 0, 3'd0, 16'h0, gD, gF);
        checkOutput($sformatf("tab%0d_data", i), gD, vecs[i].data);
        checkOutput($sformatf("tab%0d_zcv", i), {13'b0, gF}, {13'b0, vecs[i].zcv});
      end
    end
    checkRegs("tab");

    $display("[TB] back-to-back issue");
    opA = model[1]; opB = model[2];
    refExec(4'd2, opA, opB, resA, zA);
    bus.in_valid = 1'b1; bus.in_opcode = 4'd2;
    bus.in_rd = 3'd3; bus.in_rs = 3'd1; bus.in_rt = 3'd2;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b_ready_issue", {15'b0, bus.in_ready}, 16'd0);
    modelLoad(3'd3, resA);
    modelZcv = zA;
    bus.in_opcode = 4'd3; bus.in_rd = 3'd4; bus.in_rs = 3'd3; bus.in_rt = 3'd1;
    acceptEdge = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        checkOutput("b2b_wb_a", {15'b0, wb_valid}, 16'd1);
        checkOutput("b2b_data_a", wb_data, resA);
        checkOutput("b2b_ready_wb", {15'b0, bus.in_ready}, 16'd0);
      end
      if (bus.in_ready) begin
        acceptEdge = k + 1;
        break;
      end
    end
    checkOutput("b2b_accept_edge", 16'(acceptEdge), 16'd3);
    if (acceptEdge == 3) begin
      opA = model[3]; opB = model[1];
      refExec(4'd3, opA, opB, resB, zB);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("b2b_alu_a_b", alu_a, opA);
      @(posedge clk);
      @(negedge clk);
      checkOutput("b2b_wb_b", {15'b0, wb_valid}, 16'd1);
      checkOutput("b2b_data_b", wb_data, resB);
      modelLoad(3'd4, resB);
      modelZcv = zB;
      @(negedge clk);
    end else begin
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        dbg_addr = 3'(i);
        #1 model[i] = dbg_data;
      end
      modelZcv = {flag_z, flag_c, flag_v};
      @(negedge clk);
    end

    $display("[TB] illegal opcode and r0 destination");
    applyStimulus(4'hA, 3'd5, 3'd1, 3'd2, 0, 3'd0, 16'h0, gD, gF);
    applyStimulus(4'd2, 3'd0, 3'd1, 3'd2, 0, 3'd0, 16'h0, gD, gF);
    checkRegs("t5");

    $display("[TB] load collisions");
    applyStimulus(4'd2, 3'd3, 3'd1, 3'd2, 2, 3'd3, 16'h1234, gD, gF);
    applyStimulus(4'd3, 3'd5, 3'd1, 3'd2, 1, 3'd1, 16'hAAAA, gD, gF);
    applyStimulus(4'd1, 3'd6, 3'd2, 3'd1, 2, 3'd7, 16'h5A5A, gD, gF);
    checkRegs("t6");

    $display("[TB] randomized instructions");
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  rop;
      logic [15:0] rdat;
      rdat = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : 16'($urandom);
      if ($urandom_range(0, 2) == 0) loadReg(3'($urandom_range(0, 7)), rdat);
      rop = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      applyStimulus(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                    3'($urandom_range(0, 7)), 16'($urandom), gD, gF);
    end
    checkRegs("rand");

    $display("[TB] reset during issue");
    bus.in_valid = 1'b1; bus.in_opcode = 4'd2;
    bus.in_rd = 3'd3; bus.in_rs = 3'd1; bus.in_rt = 3'd2;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("midrst_in_issue", {15'b0, bus.in_ready}, 16'd0);
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    modelZcv = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst_no_wb%0d", k), {15'b0, wb_valid}, 16'd0);
    end
    checkOutput("midrst_flags", {13'b0, flag_z, flag_c, flag_v}, 16'd0);
    checkOutput("midrst_ready", {15'b0, bus.in_ready}, 16'd1);
    checkRegs("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
